pc_sequencer: RTL

- Owns the program counter, link register and fetch-side squash logic.
- Sits between instruction memory and the combinational branch decoder.
- Consumes the decoder's pc_mux/flush/lr_sel/immediate outputs and produces the next fetch address plus the instruction word presented to decode.
- Sequences the two-step BX flow: when BX decodes, it injects the BX-stall instruction, then redirects to the register target.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pc_next_calc.sv | 34 +++
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the fetch-side program counter logic.
//   NOP_INSTR / BX_STALL_INSTR : instruction words injected into decode
//   pc_mux_t                   : next-PC select codes driven by the branch decoder
//   seq_state_t                : sequencer FSM states
//   exp_flush()                : which select codes the decoder must flag with flush
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR      = 16'hBF00;
    localparam logic [15:0] BX_STALL_INSTR = 16'hBF01;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BCOND  = 3'd1,
        B      = 3'd2,
        BL     = 3'd3,
        BX_REG = 3'd4,
        BX_DEC = 3'd6
    } pc_mux_t;

    typedef enum logic {
        RUN     = 1'b0,
        BX_WAIT = 1'b1
    } seq_state_t;

    // Every redirecting or BX-related select must come with a decoder flush.
    function automatic logic exp_flush(input logic [2:0] sel);
        return (sel == 3'd1) || (sel == 3'd2) || (sel == 3'd3) ||
               (sel == 3'd4) || (sel == 3'd6);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational candidate next-PC values.
//   pc_i      : current fetch address
//   dec_pc_i  : address of the instruction currently in decode (branch base)
//   im8_i     : sign-extended conditional-branch offset
//   im11_i    : sign-extended unconditional/BL offset
//   seq_pc_o  : pc + 1
//   link_pc_o : dec_pc + 1 (branch base and BL return address)
//   bcond_pc_o: dec_pc + 1 + im8
//   b_pc_o    : dec_pc + 1 + im11
// All sums wrap modulo 2^ADDR_W.
module pc_next_calc #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] dec_pc_i,
    input  logic [ADDR_W-1:0] im8_i,
    input  logic [ADDR_W-1:0] im11_i,
    output logic [ADDR_W-1:0] seq_pc_o,
    output logic [ADDR_W-1:0] link_pc_o,
    output logic [ADDR_W-1:0] bcond_pc_o,
    output logic [ADDR_W-1:0] b_pc_o
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Candidate addresses; the sequencer FSM chooses among them.
    always_comb begin
        seq_pc_o   = pc_i + ONE;
        link_pc_o  = dec_pc_i + ONE;
        bcond_pc_o = link_pc_o + im8_i;
        b_pc_o     = link_pc_o + im11_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, link register and fetch squash control.
//   clk, rst_n       : clock, synchronous active-low reset
//   stall_i          : freezes all state
//   pc_mux_i         : next-PC select from the branch decoder
//   flush_i, lr_sel_i: decoder side-band flags, cross-checked against pc_mux_i
//   im8_i, im11_i    : sign-extended branch offsets
//   bx_target_i      : register target for BX, valid while bx_busy_o
//   imem_addr_o      : fetch address (IMem returns data one cycle later)
//   imem_rdata_i     : fetched instruction
//   instr_o, pc_d_o  : instruction presented to decode and its address
//   lr_o, lr_we_o    : link register and its one-cycle write pulse
//   bx_busy_o        : high while the BX stall instruction is in decode
//   illegal_o        : one-cycle pulse on an illegal or inconsistent select
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic [2:0]        pc_mux_i,
    input  logic              flush_i,
    input  logic              lr_sel_i,
    input  logic [ADDR_W-1:0] im8_i,
    input  logic [ADDR_W-1:0] im11_i,
    input  logic [ADDR_W-1:0] bx_target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [15:0]       imem_rdata_i,
    output logic [15:0]       instr_o,
    output logic [ADDR_W-1:0] pc_d_o,
    output logic [ADDR_W-1:0] lr_o,
    output logic              lr_we_o,
    output logic              bx_busy_o,
    output logic              illegal_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
    logic [ADDR_W-1:0] lr_q, lr_d;
    seq_state_t        state_q, state_d;
    logic              squash_q, squash_d;
    logic              lr_we_q, lr_we_d;
    logic              illegal_q, illegal_d;

    logic [ADDR_W-1:0] seq_pc_s, link_pc_s, bcond_pc_s, b_pc_s;
    logic              inconsistent_s;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
        .pc_i       (pc_q),
        .dec_pc_i   (dec_pc_q),
        .im8_i      (im8_i),
        .im11_i     (im11_i),
        .seq_pc_o   (seq_pc_s),
        .link_pc_o  (link_pc_s),
        .bcond_pc_o (bcond_pc_s),
        .b_pc_o     (b_pc_s)
    );

    // Decoder side-band flags must agree with the select it drives.
    assign inconsistent_s = (flush_i != exp_flush(pc_mux_i)) ||
                            (lr_sel_i != (pc_mux_i == 3'd3));

    // Next-state logic: stall > BX completion > squashed slot > decode select.
    always_comb begin
        pc_d      = pc_q;
        dec_pc_d  = dec_pc_q;
        lr_d      = lr_q;
        state_d   = state_q;
        squash_d  = squash_q;
        lr_we_d   = 1'b0;
        illegal_d = 1'b0;
        if (stall_i) begin
            pc_d = pc_q;
        end else if (state_q == BX_WAIT) begin
            // Decode holds BF01; only the BX_REG select may complete the BX.
            illegal_d = (pc_mux_i != 3'(BX_REG)) || inconsistent_s;
            if (pc_mux_i == 3'(BX_REG)) begin
                pc_d     = bx_target_i;
                dec_pc_d = pc_q;
                squash_d = 1'b1;
                state_d  = RUN;
            end else begin
                state_d = BX_WAIT;
            end
        end else if (squash_q) begin
            // Decode holds a squashed NOP: its select is stale, just advance.
            pc_d     = seq_pc_s;
            dec_pc_d = pc_q;
            squash_d = 1'b0;
        end else begin
            illegal_d = inconsistent_s;
            dec_pc_d  = pc_q;
            case (pc_mux_i)
                3'(SEQ): begin
                    pc_d     = seq_pc_s;
                    squash_d = 1'b0;
                end
                3'(BCOND): begin
                    pc_d     = bcond_pc_s;
                    squash_d = 1'b1;
                end
                3'(B): begin
                    pc_d     = b_pc_s;
                    squash_d = 1'b1;
                end
                3'(BL): begin
                    pc_d     = b_pc_s;
                    squash_d = 1'b1;
                    lr_d     = link_pc_s;
                    lr_we_d  = 1'b1;
                end
                3'(BX_DEC): begin
                    // Hold fetch and decode address while BF01 is injected.
                    dec_pc_d = dec_pc_q;
                    state_d  = BX_WAIT;
                end
                default: begin
                    // BX_REG outside BX_WAIT and the unused codes run sequentially.
                    pc_d      = seq_pc_s;
                    squash_d  = 1'b0;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            dec_pc_q  <= RESET_PC;
            lr_q      <= '0;
            state_q   <= RUN;
            squash_q  <= 1'b1;
            lr_we_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            dec_pc_q  <= dec_pc_d;
            lr_q      <= lr_d;
            state_q   <= state_d;
            squash_q  <= squash_d;
            lr_we_q   <= lr_we_d;
            illegal_q <= illegal_d;
        end
    end

    // Instruction to decode: BX stall word, squash bubble, or fetched word.
    always_comb begin
        if (state_q == BX_WAIT) begin
            instr_o = BX_STALL_INSTR;
        end else if (squash_q) begin
            instr_o = NOP_INSTR;
        end else begin
            instr_o = imem_rdata_i;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_d_o      = dec_pc_q;
    assign lr_o        = lr_q;
    assign lr_we_o     = lr_we_q;
    assign illegal_o   = illegal_q;
    assign bx_busy_o   = (state_q == BX_WAIT);

endmodule
